// File: rtl/aqp_esp_spi_phy.sv
// Byte-level SPI mode-0 slave front end for the ESP link.
// Oversamples the SPI pins in the clk domain; frames messages and shifts bytes in/out MSB first.
module aqp_esp_spi_phy #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       esp_ssel_n,
  input  logic       esp_sclk,
  input  logic       esp_mosi,
  output logic       esp_miso,
  output logic       msg_start,
  output logic       msg_end,
  output logic [7:0] rxdata,
  output logic       rxdata_valid,
  input  logic [7:0] txdata,
  output logic       txdata_ack
);

  logic [SYNC_STAGES-1:0] ssel_sync, sclk_sync, mosi_sync;
  logic                   ssel_hist, sclk_hist;
  logic                   ssel_s, sclk_s, mosi_s;
  logic                   ssel_fall, ssel_rise, sclk_rise, sclk_fall;

  // The ssel chain clears to 0 so a select held low through reset never looks idle; the
  // history flop holds the idle value and armed_q blocks the resulting false falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ssel_sync <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ssel_hist <= 1'b1;
      sclk_hist <= 1'b0;
    end else begin
      ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], esp_ssel_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], esp_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], esp_mosi};
      ssel_hist <= ssel_s;
      sclk_hist <= sclk_s;
    end
  end

  assign ssel_s    = ssel_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ssel_fall = ssel_hist & ~ssel_s;
  assign ssel_rise = ~ssel_hist & ssel_s;
  assign sclk_rise = ~sclk_hist & sclk_s;
  assign sclk_fall = sclk_hist & ~sclk_s;

  logic       armed_q, armed_d;
  logic       active_q, active_d;
  logic       seen_q, seen_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       valid_q, valid_d;
  logic       start_q, start_d;
  logic       end_q, end_d;
  logic       ack_q, ack_d;

  always_comb begin
    armed_d  = armed_q | ssel_s;
    active_d = active_q;
    seen_d   = seen_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    rxdata_d = rxdata_q;
    valid_d  = 1'b0;
    start_d  = 1'b0;
    end_d    = 1'b0;
    ack_d    = 1'b0;

    if (ssel_fall && armed_q) begin
      active_d = 1'b1;
      start_d  = 1'b1;
      seen_d   = 1'b0;
      cnt_d    = 3'd0;
      rx_d     = 8'h00;
      tx_d     = txdata;
      ack_d    = 1'b1;
      miso_d   = txdata[7];
    end else if (ssel_rise && active_q) begin
      // Deselect wins over any coincident sclk edge; a partial byte is dropped.
      active_d = 1'b0;
      end_d    = 1'b1;
      cnt_d    = 3'd0;
      miso_d   = 1'b0;
    end else if (active_q) begin
      if (sclk_rise) begin
        rx_d   = {rx_q[6:0], mosi_s};
        cnt_d  = cnt_q + 3'd1;
        seen_d = 1'b1;
        if (cnt_q == 3'd7) begin
          rxdata_d = {rx_q[6:0], mosi_s};
          valid_d  = 1'b1;
        end
      end else if (sclk_fall && seen_q) begin
        if (cnt_q == 3'd0) begin
          tx_d   = txdata;
          ack_d  = 1'b1;
          miso_d = txdata[7];
        end else begin
          tx_d   = {tx_q[6:0], 1'b0};
          miso_d = tx_q[6];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q  <= 1'b0;
      active_q <= 1'b0;
      seen_q   <= 1'b0;
      cnt_q    <= 3'd0;
      rx_q     <= 8'h00;
      tx_q     <= 8'h00;
      miso_q   <= 1'b0;
      rxdata_q <= 8'h00;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      armed_q  <= armed_d;
      active_q <= active_d;
      seen_q   <= seen_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      miso_q   <= miso_d;
      rxdata_q <= rxdata_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
      end_q    <= end_d;
      ack_q    <= ack_d;
    end
  end

  assign esp_miso     = miso_q;
  assign msg_start    = start_q;
  assign msg_end      = end_q;
  assign rxdata       = rxdata_q;
  assign rxdata_valid = valid_q;
  assign txdata_ack   = ack_q;

endmodule

// File: tb/tb_aqp_esp_spi_phy.sv
// Directed bench for aqp_esp_spi_phy: a bit-banged SPI master plus a consumer that
// presents tx_tab[n] after the n-th received byte of the current message.
module tb_aqp_esp_spi_phy;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       esp_ssel_n = 1'b1;
  logic       esp_sclk = 1'b0;
  logic       esp_mosi = 1'b0;
  logic       esp_miso;
  logic       msg_start, msg_end, rxdata_valid, txdata_ack;
  logic [7:0] rxdata;
  logic [7:0] txdata;

  aqp_esp_spi_phy #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .esp_ssel_n   (esp_ssel_n),
    .esp_sclk     (esp_sclk),
    .esp_mosi     (esp_mosi),
    .esp_miso     (esp_miso),
    .msg_start    (msg_start),
    .msg_end      (msg_end),
    .rxdata       (rxdata),
    .rxdata_valid (rxdata_valid),
    .txdata       (txdata),
    .txdata_ack   (txdata_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_start = 0, n_end = 0, n_valid = 0, n_ack = 0, n_both = 0;
  int last_valid_cyc = 0;
  int rise_cyc = 0;
  int v_base = 0;
  logic [7:0] rx_log [256];
  logic [7:0] tx_tab [16];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (msg_start) n_start++;
    if (msg_end) n_end++;
    if (msg_start && msg_end) n_both++;
    if (txdata_ack) n_ack++;
    if (rxdata_valid) begin
      rx_log[n_valid & 255] = rxdata;
      last_valid_cyc = cyc;
      n_valid++;
    end
  end

  assign txdata = tx_tab[(n_valid - v_base) & 15];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One message of nbits bits, MSB first; the last falling sclk edge coincides with deselect.
  task automatic xfer(input int nbits, input logic [63:0] mo, input int h,
                      output logic [63:0] mi);
    mi = '0;
    esp_ssel_n = 1'b1;
    ticks(6);
    v_base = n_valid;
    esp_ssel_n = 1'b0;
    ticks(6);
    for (int i = 0; i < nbits; i++) begin
      esp_mosi = mo[nbits-1-i];
      ticks(h);
      esp_sclk = 1'b1;
      if ((i % 8) == 7) rise_cyc = cyc;
      ticks(h);
      mi[nbits-1-i] = esp_miso;
      esp_sclk = 1'b0;
      if (i == nbits - 1) esp_ssel_n = 1'b1;
    end
    ticks(8);
  endtask

  int b_start, b_end, b_valid, b_ack;
  logic [63:0] mi;

  task automatic snap();
    b_start = n_start;
    b_end   = n_end;
    b_valid = n_valid;
    b_ack   = n_ack;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tx_tab[i] = 8'h00;

    // Reset with idle pins
    ticks(5);
    check("rst_miso", esp_miso, 0);
    check("rst_start", msg_start, 0);
    check("rst_end", msg_end, 0);
    check("rst_rxdata", rxdata, 8'h00);
    check("rst_valid", rxdata_valid, 0);
    check("rst_ack", txdata_ack, 0);
    snap();
    reset = 1'b0;
    ticks(20);
    check("idle_start", n_start - b_start, 0);
    check("idle_end", n_end - b_end, 0);
    check("idle_valid", n_valid - b_valid, 0);
    check("idle_ack", n_ack - b_ack, 0);

    // Single byte A5 at 8:1
    snap();
    xfer(8, 64'hA5, 4, mi);
    check("a5_start", n_start - b_start, 1);
    check("a5_valid", n_valid - b_valid, 1);
    check("a5_data", rx_log[b_valid & 255], 8'hA5);
    check("a5_latency", (last_valid_cyc - rise_cyc == 3) || (last_valid_cyc - rise_cyc == 4), 1);
    check("a5_end", n_end - b_end, 1);
    ticks(10);
    check("a5_hold", rxdata, 8'hA5);
    check("a5_miso_idle", esp_miso, 0);

    // Two-byte transfer with tx 3C then C3
    tx_tab[0] = 8'h3C;
    tx_tab[1] = 8'hC3;
    snap();
    xfer(16, 64'h1234, 4, mi);
    check("tx2_miso", mi[15:0], 16'h3CC3);
    check("tx2_ack", n_ack - b_ack, 2);
    check("tx2_valid", n_valid - b_valid, 2);
    check("tx2_rx0", rx_log[b_valid & 255], 8'h12);
    check("tx2_rx1", rx_log[(b_valid + 1) & 255], 8'h34);

    // 12 bits: partial remainder dropped, next message aligned
    snap();
    xfer(12, 64'h5A9, 4, mi);
    check("p12_valid", n_valid - b_valid, 1);
    check("p12_rx", rx_log[b_valid & 255], 8'h5A);
    check("p12_end", n_end - b_end, 1);
    snap();
    xfer(8, 64'h3E, 4, mi);
    check("p12_next_valid", n_valid - b_valid, 1);
    check("p12_next_rx", rx_log[b_valid & 255], 8'h3E);

    // Reset released while selected and clocking
    reset = 1'b1;
    esp_ssel_n = 1'b0;
    repeat (3) begin
      esp_sclk = 1'b1;
      ticks(2);
      esp_sclk = 1'b0;
      ticks(2);
    end
    check("mid_rst_rxdata", rxdata, 8'h00);
    reset = 1'b0;
    snap();
    for (int i = 0; i < 10; i++) begin
      esp_mosi = i[0];
      ticks(4);
      esp_sclk = 1'b1;
      ticks(4);
      esp_sclk = 1'b0;
    end
    ticks(6);
    check("mid_start", n_start - b_start, 0);
    check("mid_valid", n_valid - b_valid, 0);
    check("mid_ack", n_ack - b_ack, 0);
    check("mid_miso", esp_miso, 0);
    xfer(8, 64'h81, 4, mi);
    check("mid_81_start", n_start - b_start, 1);
    check("mid_81_valid", n_valid - b_valid, 1);
    check("mid_81_rx", rx_log[b_valid & 255], 8'h81);

    // 8-byte burst at 4:1
    for (int i = 0; i < 8; i++) tx_tab[i] = 8'hF0 + 8'(i);
    snap();
    xfer(64, 64'h0001020304050607, 2, mi);
    check("burst_valid", n_valid - b_valid, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("burst_rx%0d", i), rx_log[(b_valid + i) & 255], 64'(i));
      check($sformatf("burst_miso%0d", i), mi[63-8*i -: 8], 64'(8'hF0 + 8'(i)));
    end
    check("burst_end", n_end - b_end, 1);
    check("burst_miso_idle", esp_miso, 0);
    check("no_start_end_overlap", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
